// File: rtl/cla7_adder.sv
// ============================================================================
// cla7_adder : registered 7-bit two-level carry-lookahead adder (final CPA
//              stage of the 4x4 carry-save multiplier).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla7_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] a,
  input  logic [6:0] b,
  input  logic       in_valid,
  output logic       cout,
  output logic [7:0] result,
  output logic       out_valid
);

  logic [6:0] g;
  logic [6:0] p;
  logic [7:0] c;
  logic [6:0] s;
  logic       gg0, gp0, gg1, gp1;

  logic [7:0] result_d, result_q;
  logic       cout_d, cout_q;
  logic       out_valid_d, out_valid_q;

  // Carries are flat sum-of-products within each group; only c4 crosses groups.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = 1'b0;

    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    gg0  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp0  = p[3] & p[2] & p[1] & p[0];
    c[4] = gg0 | (gp0 & c[0]);

    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    gg1  = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]);
    gp1  = p[6] & p[5] & p[4];
    c[7] = gg1 | (gp1 & c[4]);

    s = p ^ c[6:0];
  end

  always_comb begin
    result_d    = result_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = {c[7], s};
      cout_d      = c[7];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 8'h00;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cla7_adder.sv
// ============================================================================
// tb_cla7_adder : self-checking bench for cla7_adder against an arithmetic
//                 reference (expected sum = a + b, registered one cycle).
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla7_adder;

  logic       clk;
  logic       rst_n;
  logic [6:0] a;
  logic [6:0] b;
  logic       in_valid;
  logic       cout;
  logic [7:0] result;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_res;
  logic       m_ov;

  cla7_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .cout      (cout),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".result"},    result,           m_res);
    check({tag, ".cout"},      {7'd0, cout},     {7'd0, m_res[7]});
    check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, m_ov});
  endtask

  // One clock: drive at the falling edge, compare just after the rising edge.
  task automatic cycle(input logic [6:0] ta, input logic [6:0] tb, input logic tv,
                       input string tag);
    @(negedge clk);
    a        = ta;
    b        = tb;
    in_valid = tv;
    if (tv) m_res = 8'({1'b0, ta} + {1'b0, tb});
    m_ov = tv;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Reduce the four 4x4 partial products to sum/carry vectors with 3:2 compressors.
  task automatic mult_check(input logic [3:0] x, input logic [3:0] y, input string tag);
    logic [7:0] pp0, pp1, pp2, pp3, s1, c1, s2, c2;
    pp0 = y[0] ? {4'd0, x}       : 8'd0;
    pp1 = y[1] ? {3'd0, x, 1'b0} : 8'd0;
    pp2 = y[2] ? {2'd0, x, 2'b0} : 8'd0;
    pp3 = y[3] ? {1'd0, x, 3'b0} : 8'd0;
    s1 = pp0 ^ pp1 ^ pp2;
    c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
    s2 = s1 ^ c1 ^ pp3;
    c2 = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
    if (s2[7] == 1'b0 && c2[7] == 1'b0) begin
      cycle(s2[6:0], c2[6:0], 1'b1, tag);
      check({tag, ".product"}, result, 8'(x * y));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    a        = 7'd0;
    b        = 7'd0;
    in_valid = 1'b0;
    m_res    = 8'h00;
    m_ov     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_state");

    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    cycle(7'd0,   7'd0,   1'b1, "zero");
    cycle(7'h55,  7'd0,   1'b1, "identity");
    cycle(7'h0F,  7'h01,  1'b1, "group_carry");
    cycle(7'h7F,  7'h01,  1'b1, "full_propagate");
    cycle(7'h7F,  7'h7F,  1'b1, "max_sum");
    cycle(7'h2A,  7'h15,  1'b1, "alt_bits");

    // Hold with in_valid low (inputs changed to prove they are ignored)
    cycle(7'h12,  7'h34,  1'b1, "pre_hold");
    for (int i = 0; i < 3; i++) cycle(7'h7F, 7'h7F, 1'b0, "hold");

    // Randomized stimulus with random qualifiers
    for (int i = 0; i < 200; i++)
      cycle(7'($urandom), 7'($urandom), 1'($urandom_range(0, 3) != 0), "random");

    // Exhaustive back-to-back stream
    for (int i = 0; i < 16384; i++)
      cycle(7'(i >> 7), 7'(i), 1'b1, "exhaustive");

    // Multiplier-level sums
    mult_check(4'hF, 4'hF, "mul_f_f");
    for (int i = 0; i < 16; i++) mult_check(4'h0, 4'(i), "mul_zero");
    for (int i = 0; i < 20; i++) mult_check(4'($urandom), 4'($urandom), "mul_random");

    // Asynchronous reset while a valid sum is in flight
    cycle(7'h40, 7'h22, 1'b1, "pre_reset");
    @(negedge clk);
    a        = 7'h33;
    b        = 7'h11;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    m_res = 8'h00;
    m_ov  = 1'b0;
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(7'd3, 7'd4, 1'b1, "after_reset");
    check("after_reset.seven", result, 8'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
